// File: rtl/dm_pkg.sv
// Shared definitions for the dm_1k access arbiter: FSM encoding and address limits.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    ACK    = 2'd3
  } state_e;

  localparam logic [3:0] BE_FULL          = 4'hF;
  localparam logic [9:0] DM_MAX_WORD_ADDR = 10'd1020;

endpackage

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-requester round-robin grant selection; the priority pointer lives in the caller.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic ptr_i,
  output logic gnt_o
);

  // Lone requester wins; on contention the pointer decides.
  always_comb begin
    gnt_o = 1'b0;
    if (req0_i && req1_i) gnt_o = ptr_i;
    else if (req1_i)      gnt_o = 1'b1;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin sharing of dm_1k's word port between two masters, with byte
// enables implemented as a read-modify-write through a read buffer.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [3:0]    be0,
  input  logic [3:0]    be1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout
);

  state_e        state_q, state_d;
  logic          ptr_q;
  logic          win_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    be_q;
  logic          err_q;
  logic [DW-1:0] rbuf_q;

  logic          gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [3:0]    sel_be;
  logic          sel_bad;
  logic [DW-1:0] merged;

  rr_arb2 u_rr_arb2 (
    .req0_i (req0),
    .req1_i (req1),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt)
  );

  // Winner's request fields and the alignment/range check on its address.
  always_comb begin
    sel_we    = gnt ? we1    : we0;
    sel_addr  = gnt ? addr1  : addr0;
    sel_wdata = gnt ? wdata1 : wdata0;
    sel_be    = gnt ? be1    : be0;
    sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr > AW'(DM_MAX_WORD_ADDR));
  end

  // Enabled bytes come from the write data, the rest from the word read in ACCESS.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8] : rbuf_q[8*gi +: 8];
  end

  // State, priority pointer and latched transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (req0 || req1)) begin
        win_q   <= gnt;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        be_q    <= sel_be;
        err_q   <= sel_bad;
      end
      if (state_q == ACCESS) rbuf_q <= dm_dout;
      if (state_q == ACK)    ptr_q  <= ~win_q;
    end
  end

  // Next-state logic and all outputs, decoded from the current state.
  always_comb begin
    state_d = state_q;
    ack0    = 1'b0;
    ack1    = 1'b0;
    err0    = 1'b0;
    err1    = 1'b0;
    rdata   = '0;
    busy    = (state_q != IDLE);
    dm_addr = '0;
    dm_din  = '0;
    dm_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) state_d = sel_bad ? ACK : ACCESS;
      end
      ACCESS: begin
        dm_addr = addr_q;
        if (we_q && be_q == BE_FULL) begin
          dm_we   = 1'b1;
          dm_din  = wdata_q;
          state_d = ACK;
        end else if (we_q && be_q != 4'h0) begin
          state_d = MERGE;
        end else begin
          state_d = ACK;
        end
      end
      MERGE: begin
        dm_addr = addr_q;
        dm_we   = 1'b1;
        dm_din  = merged;
        state_d = ACK;
      end
      ACK: begin
        dm_addr = addr_q;
        ack0    = ~win_q;
        ack1    = win_q;
        err0    = ~win_q & err_q;
        err1    = win_q & err_q;
        rdata   = (!we_q && !err_q) ? rbuf_q : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural dm_1k word memory.
module tb_dm_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [9:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  be0, be1;
  logic        ack0, ack1, err0, err1, busy, dm_we;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  dm_arbiter #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dm_1k model: combinational read, full-word write on the rising edge, plus a preload port.
  assign dm_dout = mem[dm_addr[9:2]];
  always @(posedge clk) begin
    if (dm_we)      mem[dm_addr[9:2]] <= dm_din;
    else if (pl_en) mem[pl_idx]       <= pl_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    tick();
    pl_en  = 1'b0;
  endtask

  // One request on one port; reports cycles to ack (-1 on timeout), dm_we cycles,
  // err, rdata at ack, and any ack seen on the other port.
  task automatic run_txn(input bit port, input bit we, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         output int cyc, output int wecnt, output logic e,
                         output logic [31:0] rd, output int other);
    bit got;
    if (port) begin we1 = we; addr1 = addr; wdata1 = wd; be1 = be; req1 = 1'b1; end
    else      begin we0 = we; addr0 = addr; wdata0 = wd; be0 = be; req0 = 1'b1; end
    cyc = 0; wecnt = 0; other = 0; e = 1'b0; rd = '0; got = 1'b0;
    while (!got && cyc < 10) begin
      tick();
      cyc++;
      if (dm_we) wecnt++;
      if (port ? ack0 : ack1) other++;
      if (port ? ack1 : ack0) begin
        got = 1'b1;
        e   = port ? err1 : err0;
        rd  = rdata;
      end
    end
    if (!got) cyc = -1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  int          cyc, wecnt, other, nack, overlap, rdbad, ackcnt;
  logic        e;
  logic [31:0] rd, w;
  bit          order [0:3];
  int          ack_cyc [0:3];

  initial begin
    rst_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    tick(); tick();

    // Reset state
    check("rst_ctl", 32'({ack0, ack1, err0, err1, busy, dm_we}), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dm_addr", 32'(dm_addr), 32'h0);
    check("rst_dm_din", dm_din, 32'h0);
    rst_n = 1'b1;
    tick();

    // Full-word write then read on port 0
    run_txn(1'b0, 1'b1, 10'h010, 32'hDEADBEEF, 4'hF, cyc, wecnt, e, rd, other);
    check("wr_full_cyc", 32'(cyc), 32'd2);
    check("wr_full_err", 32'(e), 32'd0);
    check("wr_full_we_cycles", 32'(wecnt), 32'd1);
    check("wr_full_rdata_zero", rd, 32'h0);
    w = mem[4];
    check("byte_0x010", 32'(w[7:0]), 32'hEF);
    check("byte_0x011", 32'(w[15:8]), 32'hBE);
    check("byte_0x012", 32'(w[23:16]), 32'hAD);
    check("byte_0x013", 32'(w[31:24]), 32'hDE);
    run_txn(1'b0, 1'b0, 10'h010, 32'h0, 4'h0, cyc, wecnt, e, rd, other);
    check("rd_cyc", 32'(cyc), 32'd2);
    check("rd_rdata", rd, 32'hDEADBEEF);
    check("rd_we_cycles", 32'(wecnt), 32'd0);

    // Partial write on port 1: be=0101 over 0x11223344
    preload(8'd8, 32'h11223344);
    run_txn(1'b1, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0101, cyc, wecnt, e, rd, other);
    check("pw_cyc", 32'(cyc), 32'd3);
    check("pw_err", 32'(e), 32'd0);
    check("pw_we_cycles", 32'(wecnt), 32'd1);
    check("pw_word", mem[8], 32'h11BB33DD);
    check("pw_other_ack", 32'(other), 32'd0);

    // Misaligned read errors in one cycle with no memory access
    run_txn(1'b0, 1'b0, 10'h013, 32'h0, 4'h0, cyc, wecnt, e, rd, other);
    check("err_mis_cyc", 32'(cyc), 32'd1);
    check("err_mis_err", 32'(e), 32'd1);
    check("err_mis_rdata", rd, 32'h0);
    check("err_mis_we_cycles", 32'(wecnt), 32'd0);

    // Top word 0x3FC is legal; 0x3FE is not
    run_txn(1'b0, 1'b1, 10'h3FC, 32'h12345678, 4'hF, cyc, wecnt, e, rd, other);
    check("wr_3fc_cyc", 32'(cyc), 32'd2);
    check("wr_3fc_err", 32'(e), 32'd0);
    check("wr_3fc_word", mem[255], 32'h12345678);
    run_txn(1'b0, 1'b1, 10'h3FE, 32'h9999AAAA, 4'hF, cyc, wecnt, e, rd, other);
    check("wr_3fe_cyc", 32'(cyc), 32'd1);
    check("wr_3fe_err", 32'(e), 32'd1);
    check("wr_3fe_we_cycles", 32'(wecnt), 32'd0);
    check("wr_3fe_mem_kept", mem[255], 32'h12345678);

    // Write with no byte enables: plain 2-cycle ack, memory untouched
    preload(8'd12, 32'hCAFEF00D);
    run_txn(1'b0, 1'b1, 10'h030, 32'h01020304, 4'h0, cyc, wecnt, e, rd, other);
    check("be0_cyc", 32'(cyc), 32'd2);
    check("be0_err", 32'(e), 32'd0);
    check("be0_we_cycles", 32'(wecnt), 32'd0);
    check("be0_mem_kept", mem[12], 32'hCAFEF00D);

    // Contention from reset: both ports read continuously
    preload(8'd32, 32'h0A0A0A0A);
    preload(8'd48, 32'h0B0B0B0B);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    we0 = 0; addr0 = 10'h080; be0 = '0; wdata0 = '0;
    we1 = 0; addr1 = 10'h0C0; be1 = '0; wdata1 = '0;
    req0 = 1'b1; req1 = 1'b1;
    nack = 0; overlap = 0; rdbad = 0;
    for (int c = 1; c <= 30 && nack < 4; c++) begin
      tick();
      if (ack0 && ack1) overlap++;
      if (ack0 || ack1) begin
        order[nack]   = ack1;
        ack_cyc[nack] = c;
        if (rdata !== (ack1 ? 32'h0B0B0B0B : 32'h0A0A0A0A)) rdbad++;
        nack++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    check("cont_ack_count", 32'(nack), 32'd4);
    check("cont_order", 32'({order[0], order[1], order[2], order[3]}), 32'b0101);
    check("cont_overlap", 32'(overlap), 32'd0);
    check("cont_rdata_bad", 32'(rdbad), 32'd0);
    check("cont_first_ack_cyc", 32'(ack_cyc[0]), 32'd2);
    check("cont_fourth_ack_cyc", 32'(ack_cyc[3]), 32'd11);

    // Port 0 finishes last so the pointer names port 1 before the abort
    run_txn(1'b0, 1'b0, 10'h010, 32'h0, 4'h0, cyc, wecnt, e, rd, other);
    check("pre_abort_rdata", rd, 32'hDEADBEEF);

    // Reset asserted during MERGE of a port 1 partial write
    preload(8'd16, 32'h55667788);
    we1 = 1'b1; addr1 = 10'h040; wdata1 = 32'h0; be1 = 4'b0011; req1 = 1'b1;
    tick();
    tick();
    check("abort_in_merge_we", 32'(dm_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ctl", 32'({ack0, ack1, err0, err1, busy, dm_we}), 32'h0);
    check("abort_dm_addr", 32'(dm_addr), 32'h0);
    check("abort_dm_din", dm_din, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    req1 = 1'b0;
    ackcnt = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (ack0 || ack1) ackcnt++;
    end
    rst_n = 1'b1;
    tick();
    if (ack0 || ack1) ackcnt++;
    check("abort_no_ack", 32'(ackcnt), 32'd0);
    check("abort_mem_kept", mem[16], 32'h55667788);

    // After reset the pointer favours port 0 again
    we0 = 0; addr0 = 10'h010; we1 = 0; addr1 = 10'h0C0;
    req0 = 1'b1; req1 = 1'b1;
    nack = 0;
    for (int c = 1; c <= 10 && nack == 0; c++) begin
      tick();
      if (ack0 || ack1) begin
        nack = 1;
        order[0] = ack1;
        rd = rdata;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    check("post_rst_acked", 32'(nack), 32'd1);
    check("post_rst_winner", 32'(order[0]), 32'd0);
    check("post_rst_rdata", rd, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
